// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, reads words over a req/ack
// handshake and buffers them with their PCs in a prefetch FIFO for decode.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic        inst_valid
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      PC_INIT = RESET_PC & 16'hFFFE;

    // IDLE: no request | REQ: fetching at pc | DRAIN: waiting out a pre-redirect response
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic             req_q, req_d;
    logic [15:0]      addr_q, addr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      fifo_inst_q [FIFO_DEPTH];
    logic [15:0]      fifo_inst_d [FIFO_DEPTH];
    logic [15:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [15:0]      fifo_pc_d   [FIFO_DEPTH];

    logic             xfer;
    logic             deq;
    logic             enq;
    logic [CNT_W-1:0] count_after;
    logic             space;
    logic [15:0]      pc_inc;

    // The completing request is no longer outstanding, so room is judged on the post-edge count alone.
    always_comb begin
        xfer        = req_q && imem_ack;
        deq         = (count_q != '0) && !stall;
        enq         = xfer && (state_q == REQ);
        count_after = count_q - {{PTR_W{1'b0}}, deq} + {{PTR_W{1'b0}}, enq};
        space       = count_after < DEPTH_C;
        pc_inc      = pc_q + 16'd2;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_after;
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;

        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (enq) begin
            fifo_inst_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]   = pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (space) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (xfer) begin
                    pc_d = pc_inc;
                    if (space) begin
                        req_d  = 1'b1;
                        addr_d = pc_inc;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (xfer) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Redirect wins over everything; an unanswered request must still be held until acked.
        if (redirect) begin
            pc_d     = redirect_pc & 16'hFFFE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (req_q && !imem_ack) begin
                state_d = DRAIN;
                req_d   = 1'b1;
                addr_d  = addr_q;
            end else begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= PC_INIT;
            req_q    <= 1'b0;
            addr_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 16'h0000;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : 16'h0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps, expected fetch stream held in a
// scoreboard queue and compared whenever the DUT presents an instruction.
module tb_fetch_stage;
    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ack, model_ack, man_ack, man_mode;
    logic [15:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] inst, inst_pc;
    logic        inst_valid;

    logic        imem_req2, ack2, inst_valid2;
    logic        zero2 = 1'b0;
    logic [15:0] imem_addr2, rdata2, inst2, inst_pc2;
    logic [15:0] zero16 = 16'h0000;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp2_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   wait1 = 0;
    int   wait2 = 0;
    int   mem_wait = 0;
    int   mem_limit = 0;
    int   wcnt = 0;
    int   n2 = 0;
    int   last_pop = 0;
    logic gap_mode = 1'b0;
    logic have_last = 1'b0;
    logic found;
    logic prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
    logic [15:0] prev_addr = 16'h0;

    fetch_stage #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) u_dut (
        .clk_in(clk_in), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
    );

    fetch_stage #(.RESET_PC(16'hFFFC), .FIFO_DEPTH(2)) u_dut2 (
        .clk_in(clk_in), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .stall(zero2), .redirect(zero2), .redirect_pc(zero16),
        .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2)
    );

    always #5 clk_in = ~clk_in;

    // Memory for the main DUT: ack after mem_wait cycles, only below mem_limit.
    assign model_ack  = imem_req && (wcnt == mem_wait) && ({16'h0, imem_addr} < mem_limit);
    assign imem_ack   = man_mode ? man_ack : model_ack;
    assign imem_rdata = imem_addr ^ 16'hA5A5;

    always @(posedge clk_in or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Second DUT: zero-wait memory that answers its first four requests only.
    assign ack2   = imem_req2 && (n2 < 4);
    assign rdata2 = imem_addr2 ^ 16'hA5A5;

    always @(posedge clk_in) begin
        if (!reset && imem_req2 && ack2) n2 <= n2 + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = pc ^ 16'hA5A5;
        return e;
    endfunction

    task automatic check_out();
        if (inst_valid !== 1'b1) begin
            chk16("idle_inst", inst, 16'h0000);
            chk16("idle_inst_pc", inst_pc, 16'h0000);
            if (exp_q.size() != 0) begin
                wait1++;
                if (wait1 > 40) begin
                    chk16("timeout_pending", 16'(exp_q.size()), 16'h0000);
                    exp_q.delete();
                    wait1 = 0;
                end
            end
        end else if (exp_q.size() == 0) begin
            chk1("unexpected_valid", inst_valid, 1'b0);
        end else begin
            wait1 = 0;
            chk16("inst_pc", inst_pc, exp_q[0].pc);
            chk16("inst", inst, exp_q[0].inst);
            if (!stall) begin
                if (gap_mode && have_last) chk16("inst_gap", 16'(cyc - last_pop), 16'd4);
                have_last = 1'b1;
                last_pop  = cyc;
                void'(exp_q.pop_front());
            end
        end

        if (inst_valid2 !== 1'b1) begin
            chk16("idle_inst2", inst2, 16'h0000);
            if (exp2_q.size() != 0) begin
                wait2++;
                if (wait2 > 40) begin
                    chk16("timeout_pending2", 16'(exp2_q.size()), 16'h0000);
                    exp2_q.delete();
                    wait2 = 0;
                end
            end
        end else if (exp2_q.size() == 0) begin
            chk1("unexpected_valid2", inst_valid2, 1'b0);
        end else begin
            wait2 = 0;
            chk16("wrap_inst_pc", inst_pc2, exp2_q[0].pc);
            chk16("wrap_inst", inst2, exp2_q[0].inst);
            void'(exp2_q.pop_front());
        end
    endtask

    task automatic step();
        check_out();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        cyc = 0;
        have_last = 1'b0;
    endtask

    // Handshake stability, FIFO bounds and PC alignment, checked mid-cycle.
    always @(negedge clk_in) begin
        if (!reset && !prev_rst && prev_req && !prev_ack) begin
            chk1("hs_req_hold", imem_req, 1'b1);
            chk16("hs_addr_hold", imem_addr, prev_addr);
        end
        if (!reset) begin
            chk1("fifo_bound", (u_dut.count_q <= 2), 1'b1);
            chk1("inst_pc_lsb", inst_pc[0], 1'b0);
        end
        prev_req  <= imem_req;
        prev_ack  <= imem_ack;
        prev_addr <= imem_addr;
        prev_rst  <= reset;
    end

    initial begin
        stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        man_mode = 1'b0; man_ack = 1'b0;
        exp2_q.push_back(mk(16'hFFFC));
        exp2_q.push_back(mk(16'hFFFE));
        exp2_q.push_back(mk(16'h0000));
        exp2_q.push_back(mk(16'h0002));
        #1 reset = 1'b1;
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk16("rst_addr", imem_addr, 16'h0000);
        chk16("rst_inst", inst, 16'h0000);
        chk16("rst_inst_pc", inst_pc, 16'h0000);
        chk1("rst_valid", inst_valid, 1'b0);

        // Zero-wait stream from reset
        mem_wait = 0; mem_limit = 8;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(16'(2 * i)));
        @(posedge clk_in);
        @(posedge clk_in);
        #1 reset = 1'b0;
        chk1("t1_c0_req", imem_req, 1'b0);
        step();
        chk1("t1_c1_req", imem_req, 1'b1);
        chk16("t1_c1_addr", imem_addr, 16'h0000);
        chk1("t1_c1_valid", inst_valid, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk1("t1_stream_valid", inst_valid, 1'b1);
            step();
        end
        for (int i = 0; i < 6; i++) step();
        chk16("t1_drained", 16'(exp_q.size()), 16'h0000);
        chk16("t5_wrap_drained", 16'(exp2_q.size()), 16'h0000);

        // Three wait states
        mem_wait = 3; mem_limit = 6; gap_mode = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(16'(2 * i)));
        reset_dut();
        for (int i = 0; i < 20; i++) step();
        gap_mode = 1'b0;
        chk16("t2_drained", 16'(exp_q.size()), 16'h0000);

        // Stall fills the FIFO
        mem_wait = 0; mem_limit = 12;
        for (int i = 0; i < 6; i++) exp_q.push_back(mk(16'(2 * i)));
        reset_dut();
        begin
            int   stall_left;
            logic seen4;
            stall_left = 0;
            seen4 = 1'b0;
            for (int i = 0; i < 25; i++) begin
                if (!seen4 && inst_valid && inst_pc == 16'h0004) begin
                    seen4 = 1'b1;
                    stall_left = 5;
                end
                stall = (stall_left != 0);
                if (stall_left != 0 && stall_left < 5) begin
                    chk1("t3_req_dropped", imem_req, 1'b0);
                    chk16("t3_hold_pc", inst_pc, 16'h0004);
                end
                if (stall_left != 0) stall_left--;
                step();
            end
            stall = 1'b0;
            chk1("t3_stall_seen", seen4, 1'b1);
        end
        chk16("t3_drained", 16'(exp_q.size()), 16'h0000);

        // Redirect during an outstanding wait-state request
        mem_wait = 3; mem_limit = 'h104;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(16'(2 * i)));
        reset_dut();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 16'h0006) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk1("t4_reach_addr6", found, 1'b1);
        step();
        chk1("t4_still_waiting", imem_ack, 1'b0);
        chk16("t4_pre_redirect_drained", 16'(exp_q.size()), 16'h0000);
        exp_q.delete();
        exp_q.push_back(mk(16'h0100));
        exp_q.push_back(mk(16'h0102));
        redirect = 1'b1; redirect_pc = 16'h0101;
        step();
        redirect = 1'b0;
        chk1("t4_drain_req", imem_req, 1'b1);
        chk16("t4_drain_addr", imem_addr, 16'h0006);
        chk1("t4_flushed", inst_valid, 1'b0);
        for (int i = 0; i < 25; i++) step();
        chk16("t4_drained", 16'(exp_q.size()), 16'h0000);

        // Reset during an outstanding request, ack arriving in reset
        mem_wait = 3; mem_limit = 2;
        reset_dut();
        step();
        chk1("t6_req_up", imem_req, 1'b1);
        step();
        #2 reset = 1'b1;
        #1;
        chk1("t6_req_drop", imem_req, 1'b0);
        chk16("t6_addr_clear", imem_addr, 16'h0000);
        man_mode = 1'b1; man_ack = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1 reset = 1'b0;
        cyc = 0;
        chk1("t6_c0_req", imem_req, 1'b0);
        exp_q.push_back(mk(16'h0000));
        step();
        man_mode = 1'b0; man_ack = 1'b0;
        chk1("t6_c1_req", imem_req, 1'b1);
        chk16("t6_c1_addr", imem_addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            chk1("t6_no_stale", inst_valid, 1'b0);
            step();
        end
        chk1("t6_first_valid", inst_valid, 1'b1);
        chk16("t6_first_pc", inst_pc, 16'h0000);
        for (int i = 0; i < 10; i++) step();
        chk16("t6_drained", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
